// File: rtl/mc68k_bus_sequencer_if.sv
// Pi-side request/response handshake plus the 68000 bus pins owned by the bus sequencer.
// The sequencer takes the slave view; the Pi-side decoder and bus model take the master view.
interface mc68k_bus_sequencer_if;
    logic        REQ;
    logic        REQ_RNW;
    logic [22:0] REQ_ADDR;
    logic [15:0] REQ_WDATA;
    logic        REQ_UDS;
    logic        REQ_LDS;
    logic [2:0]  REQ_FC;
    logic        BUSY;
    logic        ACK;
    logic        ERR;
    logic [15:0] RDATA;
    logic [22:0] A_OUT;
    logic [2:0]  FC_OUT;
    logic [15:0] D_OUT;
    logic        A_DRIVE;
    logic        FC_DRIVE;
    logic        D_DRIVE;
    logic        CTRL_DRIVE;
    logic        nAS_OUT;
    logic        nUDS_OUT;
    logic        nLDS_OUT;
    logic        RnW_OUT;
    logic [15:0] D_IN;
    logic        nDTACK;
    logic        nBERR;

    modport slave (
        input  REQ, REQ_RNW, REQ_ADDR, REQ_WDATA, REQ_UDS, REQ_LDS, REQ_FC,
        input  D_IN, nDTACK, nBERR,
        output BUSY, ACK, ERR, RDATA,
        output A_OUT, FC_OUT, D_OUT, A_DRIVE, FC_DRIVE, D_DRIVE, CTRL_DRIVE,
        output nAS_OUT, nUDS_OUT, nLDS_OUT, RnW_OUT
    );

    modport master (
        output REQ, REQ_RNW, REQ_ADDR, REQ_WDATA, REQ_UDS, REQ_LDS, REQ_FC,
        output D_IN, nDTACK, nBERR,
        input  BUSY, ACK, ERR, RDATA,
        input  A_OUT, FC_OUT, D_OUT, A_DRIVE, FC_DRIVE, D_DRIVE, CTRL_DRIVE,
        input  nAS_OUT, nUDS_OUT, nLDS_OUT, RnW_OUT
    );
endinterface

// File: rtl/mc68k_bus_sequencer.sv
// Runs one 68000 bus cycle (S0-S7) per Pi request, stepping on synchronised MC_CLK edges
// in the SYS_CLK domain, with DTACK wait states, BERR and wait-state timeout termination.
module mc68k_bus_sequencer #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                  SYS_CLK,
    input  logic                  SYS_RESET,
    input  logic                  MC_CLK,
    mc68k_bus_sequencer_if.slave  bus
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7
    } state_t;

    logic [2:0] mc_sync_q;
    logic [1:0] dtack_sync_q;
    logic [1:0] berr_sync_q;

    // NOTE: non-blocking assignments make every flop sample the previous stage's old value;
    // blocking ones would collapse the synchroniser chain into a single flop.
    always_ff @(posedge SYS_CLK or posedge SYS_RESET) begin
        if (SYS_RESET) begin
            mc_sync_q    <= '0;
            dtack_sync_q <= '1;
            berr_sync_q  <= '1;
        end else begin
            mc_sync_q    <= {mc_sync_q[1:0], MC_CLK};
            dtack_sync_q <= {dtack_sync_q[0], bus.nDTACK};
            berr_sync_q  <= {berr_sync_q[0], bus.nBERR};
        end
    end

    logic mc_rise, mc_fall, dtack_n, berr_n;
    assign mc_rise = mc_sync_q[1] & ~mc_sync_q[2];
    assign mc_fall = ~mc_sync_q[1] & mc_sync_q[2];
    assign dtack_n = dtack_sync_q[1];
    assign berr_n  = berr_sync_q[1];

    state_t      state_q;
    logic        busy_q, ack_q, err_q, err_pend_q;
    logic [15:0] rdata_q;
    logic        lat_rnw_q, lat_uds_q, lat_lds_q;
    logic [22:0] lat_addr_q;
    logic [15:0] lat_wdata_q;
    logic [2:0]  lat_fc_q;
    logic [22:0] a_q;
    logic [2:0]  fc_q;
    logic [15:0] d_q;
    logic        a_drv_q, fc_drv_q, d_drv_q, ctrl_drv_q;
    logic        as_n_q, uds_n_q, lds_n_q, rnw_q;
    logic [8:0]  tmo_cnt_q;

    logic [9:0]  tmo_inc;
    logic        tmo_hit;
    assign tmo_inc = {1'b0, tmo_cnt_q} + 10'd1;
    assign tmo_hit = (tmo_inc >= 10'(TIMEOUT));

    always_ff @(posedge SYS_CLK or posedge SYS_RESET) begin
        if (SYS_RESET) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            err_pend_q  <= 1'b0;
            rdata_q     <= '0;
            lat_rnw_q   <= 1'b1;
            lat_uds_q   <= 1'b0;
            lat_lds_q   <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_fc_q    <= '0;
            a_q         <= '0;
            fc_q        <= '0;
            d_q         <= '0;
            a_drv_q     <= 1'b0;
            fc_drv_q    <= 1'b0;
            d_drv_q     <= 1'b0;
            ctrl_drv_q  <= 1'b0;
            as_n_q      <= 1'b1;
            uds_n_q     <= 1'b1;
            lds_n_q     <= 1'b1;
            rnw_q       <= 1'b1;
            tmo_cnt_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            if (bus.REQ && !busy_q) begin
                busy_q      <= 1'b1;
                err_q       <= 1'b0;
                lat_rnw_q   <= bus.REQ_RNW;
                lat_addr_q  <= bus.REQ_ADDR;
                lat_wdata_q <= bus.REQ_WDATA;
                lat_fc_q    <= bus.REQ_FC;
                // Neither lane selected means a word access: both strobes.
                lat_uds_q   <= bus.REQ_UDS | ~bus.REQ_LDS;
                lat_lds_q   <= bus.REQ_LDS | ~bus.REQ_UDS;
            end

            case (state_q)
                ST_IDLE: if (mc_rise && busy_q) begin
                    state_q    <= ST_S0;
                    a_q        <= lat_addr_q;
                    fc_q       <= lat_fc_q;
                    rnw_q      <= lat_rnw_q;
                    a_drv_q    <= 1'b1;
                    fc_drv_q   <= 1'b1;
                    ctrl_drv_q <= 1'b1;
                    tmo_cnt_q  <= '0;
                    err_pend_q <= 1'b0;
                end
                ST_S0: if (mc_fall) state_q <= ST_S1;
                ST_S1: if (mc_rise) begin
                    state_q <= ST_S2;
                    as_n_q  <= 1'b0;
                    if (lat_rnw_q) begin
                        uds_n_q <= ~lat_uds_q;
                        lds_n_q <= ~lat_lds_q;
                    end else begin
                        d_q     <= lat_wdata_q;
                        d_drv_q <= 1'b1;
                    end
                end
                ST_S2: if (mc_fall) state_q <= ST_S3;
                ST_S3: if (mc_rise) begin
                    state_q <= ST_S4;
                    if (!lat_rnw_q) begin
                        uds_n_q <= ~lat_uds_q;
                        lds_n_q <= ~lat_lds_q;
                    end
                end
                ST_S4: if (mc_fall) begin
                    if (!berr_n || (dtack_n && tmo_hit)) begin
                        state_q    <= ST_S7;
                        err_pend_q <= 1'b1;
                        as_n_q     <= 1'b1;
                        uds_n_q    <= 1'b1;
                        lds_n_q    <= 1'b1;
                    end else if (!dtack_n) begin
                        state_q <= ST_S5;
                    end
                    if (berr_n && dtack_n && !tmo_inc[9]) tmo_cnt_q <= tmo_inc[8:0];
                end
                ST_S5: if (mc_rise) state_q <= ST_S6;
                ST_S6: if (mc_fall) begin
                    state_q <= ST_S7;
                    if (lat_rnw_q) rdata_q <= bus.D_IN;
                    as_n_q  <= 1'b1;
                    uds_n_q <= 1'b1;
                    lds_n_q <= 1'b1;
                end
                ST_S7: if (mc_rise) begin
                    state_q    <= ST_IDLE;
                    a_drv_q    <= 1'b0;
                    fc_drv_q   <= 1'b0;
                    d_drv_q    <= 1'b0;
                    ctrl_drv_q <= 1'b0;
                    rnw_q      <= 1'b1;
                    ack_q      <= 1'b1;
                    err_q      <= err_pend_q;
                    busy_q     <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.BUSY       = busy_q;
    assign bus.ACK        = ack_q;
    assign bus.ERR        = err_q;
    assign bus.RDATA      = rdata_q;
    assign bus.A_OUT      = a_q;
    assign bus.FC_OUT     = fc_q;
    assign bus.D_OUT      = d_q;
    assign bus.A_DRIVE    = a_drv_q;
    assign bus.FC_DRIVE   = fc_drv_q;
    assign bus.D_DRIVE    = d_drv_q;
    assign bus.CTRL_DRIVE = ctrl_drv_q;
    assign bus.nAS_OUT    = as_n_q;
    assign bus.nUDS_OUT   = uds_n_q;
    assign bus.nLDS_OUT   = lds_n_q;
    assign bus.RnW_OUT    = rnw_q;
endmodule
